data_mem_controller: RTL and testbench

- Slave side of the CPU's `memory_bus`; consumes the load/store requests that the execute stage dispatches.
- Returns load data to the writeback stage.
- Translates BYTE/WORD/DWORD byte-addressed accesses onto a 32-bit-wide synchronous block RAM with per-byte write enables.
- Sequences the RAM's fixed read latency behind a `busy` handshake.

---
 rtl/data_mem_controller.sv | 158 +++++++++++++++
 tb/tb_data_mem_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_controller.sv
// rtl/data_mem_controller.sv - load/store slave translating byte-addressed accesses onto a 32-bit block RAM
//
// Purpose: accepts one load or store at a time from the execute stage and maps
// BYTE/WORD/DWORD accesses onto a 32-bit synchronous RAM with per-byte write enables.
// It sequences the RAM read latency behind a registered busy handshake.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-high reset
//   addr, mem_width       byte address and access width (0=BYTE, 1=WORD, 2=DWORD)
//   dispatch_read/write   request strobes, sampled only while idle
//   write_data            store data, right-justified
//   read_data             load result, right-justified, zero-extended, held until next load
//   busy                  request in flight
//   access_err            sticky error flag
//   ram_addr/we/din/dout  block RAM interface
module data_mem_controller #(
  parameter int DEPTH       = 4096,
  parameter int RAM_LATENCY = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [31:0]              addr,
  input  logic [1:0]               mem_width,
  input  logic                     dispatch_read,
  input  logic                     dispatch_write,
  input  logic [31:0]              write_data,
  output logic [31:0]              read_data,
  output logic                     busy,
  output logic                     access_err,
  output logic [$clog2(DEPTH)-1:0] ram_addr,
  output logic [3:0]               ram_we,
  output logic [31:0]              ram_din,
  input  logic [31:0]              ram_dout
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [2:0] LAT_INIT = 3'(RAM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_CAPTURE, WR} state_t;

  state_t      state, state_nx;
  logic [2:0]  lat_cnt;
  logic [1:0]  lane_q;
  logic [1:0]  width_q;
  logic        accept;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [3:0]  we_calc;
  logic [31:0] din_calc;
  logic [31:0] dout_shifted;
  logic [31:0] rd_sel;

  assign accept = (state == IDLE) && (dispatch_read || dispatch_write);

  // Request decode
  always_comb begin
    misaligned   = ((mem_width == 2'd1) && addr[0]) ||
                   ((mem_width == 2'd2) && (addr[1:0] != 2'b00));
    out_of_range = addr >= 32'(4 * DEPTH);
    req_err      = (dispatch_read && dispatch_write) || (mem_width == 2'd3) ||
                   misaligned || out_of_range;
  end

  // Lane steering for stores: enables shifted to the lane, data replicated
  // across all lanes so the enabled byte(s) always see the right bits.
  always_comb begin
    we_calc  = 4'b1111;
    din_calc = write_data;
    case (mem_width)
      2'd0: begin
        we_calc  = 4'b0001 << addr[1:0];
        din_calc = {4{write_data[7:0]}};
      end
      2'd1: begin
        we_calc  = 4'b0011 << addr[1:0];
        din_calc = {2{write_data[15:0]}};
      end
      default: begin
        we_calc  = 4'b1111;
        din_calc = write_data;
      end
    endcase
  end

  // Lane extraction for loads, using the lane/width latched at accept
  always_comb begin
    dout_shifted = ram_dout >> {lane_q, 3'b000};
    case (width_q)
      2'd0:    rd_sel = {24'b0, dout_shifted[7:0]};
      2'd1:    rd_sel = {16'b0, dout_shifted[15:0]};
      default: rd_sel = ram_dout;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  // FSM: next state. Error requests borrow WR for their single busy cycle
  // with no write enable raised.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err || dispatch_write) state_nx = WR;
          else                           state_nx = RD_WAIT;
        end
      end
      RD_WAIT:    if (lat_cnt == 3'd0) state_nx = RD_CAPTURE;
      RD_CAPTURE: state_nx = IDLE;
      WR:         state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // FSM: outputs. busy derives only from the state register.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      read_data  <= '0;
      access_err <= 1'b0;
      ram_addr   <= '0;
      ram_we     <= '0;
      ram_din    <= '0;
      lat_cnt    <= '0;
      lane_q     <= '0;
      width_q    <= '0;
    end else begin
      ram_we <= '0;
      if (accept) begin
        lane_q  <= addr[1:0];
        width_q <= mem_width;
        lat_cnt <= LAT_INIT;
        if (req_err) begin
          access_err <= 1'b1;
        end else begin
          ram_addr <= addr[AW+1:2];
          if (dispatch_write) begin
            ram_we  <= we_calc;
            ram_din <= din_calc;
          end
        end
      end else begin
        if ((state == RD_WAIT) && (lat_cnt != 3'd0)) lat_cnt <= lat_cnt - 3'd1;
        if (state == RD_CAPTURE)                      read_data <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// tb/tb_data_mem_controller.sv - directed self-checking bench for data_mem_controller
module tb_data_mem_controller;

  localparam int DEPTH = 4096;
  localparam int RL    = 2;
  localparam int AW    = $clog2(DEPTH);

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [31:0]   addr;
  logic [1:0]    mem_width;
  logic          dispatch_read;
  logic          dispatch_write;
  logic [31:0]   write_data;
  logic [31:0]   read_data;
  logic          busy;
  logic          access_err;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_we;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;

  data_mem_controller #(.DEPTH(DEPTH), .RAM_LATENCY(RL)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .addr(addr), .mem_width(mem_width),
    .dispatch_read(dispatch_read), .dispatch_write(dispatch_write),
    .write_data(write_data), .read_data(read_data), .busy(busy),
    .access_err(access_err), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk_in = ~clk_in;

  // Behavioural RAM with RL-cycle read pipeline and byte write enables
  logic [31:0] mem  [DEPTH] = '{default: 32'h0};
  logic [31:0] pipe [RL]    = '{default: 32'h0};

  always @(posedge clk_in) begin
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    pipe[0] <= mem[ram_addr];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_dout = pipe[RL-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Observations from the last request
  logic [3:0]  o_we;
  logic [31:0] o_din;
  logic [31:0] o_addr;
  logic [3:0]  we_or;
  int          n_busy;

  task automatic wait_idle();
    n_busy = 0;
    while (busy && n_busy < 20) begin
      n_busy++;
      @(posedge clk_in); #1;
      we_or |= ram_we;
    end
  endtask

  task automatic req(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [1:0] w, input logic [31:0] wd);
    @(negedge clk_in);
    dispatch_read = rd; dispatch_write = wr; addr = a; mem_width = w; write_data = wd;
    @(posedge clk_in); #1;
    dispatch_read = 1'b0; dispatch_write = 1'b0;
    o_we   = ram_we;
    o_din  = ram_din;
    o_addr = 32'(ram_addr);
    we_or  = ram_we;
    wait_idle();
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
  endtask

  typedef struct {
    string       tag;
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [1:0]  w;
  } err_vec_t;

  err_vec_t errs[5];

  initial begin
    rst_in = 1'b1; addr = '0; mem_width = '0; dispatch_read = 1'b0;
    dispatch_write = 1'b0; write_data = '0;
    errs[0] = '{"lw_0x11",   1'b1, 1'b0, 32'h11,          2'd2};
    errs[1] = '{"sh_0x05",   1'b0, 1'b1, 32'h05,          2'd1};
    errs[2] = '{"oor",       1'b1, 1'b0, 32'(4 * DEPTH),  2'd0};
    errs[3] = '{"both",      1'b1, 1'b1, 32'h10,          2'd2};
    errs[4] = '{"width3",    1'b1, 1'b0, 32'h10,          2'd3};

    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    check("rst_busy",  32'(busy),       32'h0);
    check("rst_rdata", read_data,       32'h0);
    check("rst_err",   32'(access_err), 32'h0);
    check("rst_we",    32'(ram_we),     32'h0);
    check("rst_addr",  32'(ram_addr),   32'h0);
    check("rst_din",   ram_din,         32'h0);

    // DWORD store then load
    req(1'b0, 1'b1, 32'h10, 2'd2, 32'hDEADBEEF);
    check("sw_we",   32'(o_we), 32'hF);
    check("sw_addr", o_addr,    32'h4);
    check("sw_din",  o_din,     32'hDEADBEEF);
    check("sw_busy", n_busy,    1);
    req(1'b1, 1'b0, 32'h10, 2'd2, 32'h0);
    check("lw_busy", n_busy,    RL + 1);
    check("lw_data", read_data, 32'hDEADBEEF);

    // Byte lanes
    req(1'b0, 1'b1, 32'h13, 2'd0, 32'h000000AA);
    check("sb_we",  32'(o_we), 32'h8);
    check("sb_din", o_din,     32'hAAAAAAAA);
    req(1'b1, 1'b0, 32'h10, 2'd2, 32'h0);
    check("lw_after_sb", read_data, 32'hAAADBEEF);
    req(1'b1, 1'b0, 32'h12, 2'd0, 32'h0);
    check("lbu_0x12", read_data, 32'h000000AD);

    // Halfword
    req(1'b0, 1'b1, 32'h20, 2'd2, 32'h55667788);
    req(1'b0, 1'b1, 32'h22, 2'd1, 32'h1234CAFE);
    check("sh_we",  32'(o_we), 32'hC);
    check("sh_din", o_din,     32'hCAFECAFE);
    req(1'b1, 1'b0, 32'h22, 2'd1, 32'h0);
    check("lhu_0x22", read_data, 32'h0000CAFE);
    req(1'b1, 1'b0, 32'h20, 2'd1, 32'h0);
    check("lhu_0x20", read_data, 32'h00007788);

    // Errors, each from a clean state with a known prior load
    foreach (errs[i]) begin
      do_reset();
      req(1'b1, 1'b0, 32'h10, 2'd2, 32'h0);
      check({errs[i].tag, "_pre_err"}, 32'(access_err), 32'h0);
      req(errs[i].rd, errs[i].wr, errs[i].a, errs[i].w, 32'hFFFFFFFF);
      check({errs[i].tag, "_err"},   32'(access_err), 32'h1);
      check({errs[i].tag, "_we"},    32'(we_or),      32'h0);
      check({errs[i].tag, "_rdata"}, read_data,       32'hAAADBEEF);
      check({errs[i].tag, "_busy"},  n_busy,          1);
    end
    req(1'b1, 1'b0, 32'h10, 2'd2, 32'h0);
    check("err_sticky", 32'(access_err), 32'h1);

    // Ignore while busy
    req(1'b0, 1'b1, 32'h30, 2'd2, 32'h13572468);
    @(negedge clk_in);
    dispatch_read = 1'b1; addr = 32'h10; mem_width = 2'd2;
    @(posedge clk_in); #1;
    dispatch_read = 1'b0;
    we_or = ram_we;
    dispatch_write = 1'b1; addr = 32'h30; mem_width = 2'd2; write_data = 32'hFFFFFFFF;
    @(posedge clk_in); #1;
    we_or |= ram_we;
    dispatch_write = 1'b0;
    wait_idle();
    check("ign_we",    32'(we_or), 32'h0);
    check("ign_rdata", read_data,  32'hAAADBEEF);
    req(1'b1, 1'b0, 32'h30, 2'd2, 32'h0);
    check("ign_mem", read_data, 32'h13572468);

    // Reset mid-read
    @(negedge clk_in);
    dispatch_read = 1'b1; addr = 32'h20; mem_width = 2'd2;
    @(posedge clk_in); #1;
    dispatch_read = 1'b0;
    @(posedge clk_in); #1;
    check("mid_busy2", 32'(busy), 32'h1);
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    check("mid_busy",  32'(busy),       32'h0);
    check("mid_rdata", read_data,       32'h0);
    check("mid_err",   32'(access_err), 32'h0);
    check("mid_we",    32'(ram_we),     32'h0);
    req(1'b1, 1'b0, 32'h20, 2'd2, 32'h0);
    check("post_busy", n_busy,    RL + 1);
    check("post_data", read_data, 32'hCAFE7788);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
